// File: rtl/conv1_window_ctrl_if.sv
// Handshake bundle for conv1_window_ctrl: the pixel stream coming in and the
// 3x3 window going out to the conv1 calc.
interface conv1_window_ctrl_if;
  logic pix_in, pix_valid, pix_ready;
  logic pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7, pixel_8;
  logic valid_out_buf, out_ready;

  modport slave (
    input  pix_in, pix_valid, out_ready,
    output pix_ready, valid_out_buf,
    output pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7, pixel_8
  );

  modport master (
    output pix_in, pix_valid, out_ready,
    input  pix_ready, valid_out_buf,
    input  pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7, pixel_8
  );
endinterface

// File: rtl/conv1_window_ctrl.sv
// Raster pixel stream -> two line buffers -> 3x3 window for the binary conv1 stage.
// Optional macro CONV1_WIN_CNT_EN adds a saturating 10-bit win_count output.
module conv1_window_ctrl #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int COL_W = 5,
  parameter int ROW_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  conv1_window_ctrl_if.slave win,
  output logic busy,
  output logic frame_done
`ifdef CONV1_WIN_CNT_EN
  , output logic [9:0] win_count
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_e;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  state_e state_q, state_d;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [IMG_W-1:0] lb_top, lb_mid;
  logic [8:0] w;   // w[k] drives pixel_k
  logic vld, done_d, accept, col_wrap, start_ok;

  assign col_wrap = (col == COL_LAST);
  assign start_ok = (state_q == IDLE) && start;
  assign busy     = (state_q != IDLE);

  // Stalled window blocks intake so the window register cannot be overwritten.
  assign win.pix_ready = ((state_q == FILL) || (state_q == RUN)) && !(vld && !win.out_ready);
  assign accept        = win.pix_valid && win.pix_ready;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = FILL;
      FILL: if (accept && col_wrap && row == ROW_ONE) state_d = RUN;
      RUN:  if (accept && col_wrap && row == ROW_LAST) state_d = DONE;
      DONE: if (!vld || win.out_ready) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_done <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (start_ok) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Line buffers are always written before being read into a valid window.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[col] <= lb_mid[col];
      lb_mid[col] <= win.pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w   <= '0;
      vld <= 1'b0;
    end else if (accept) begin
      w   <= {win.pix_in, w[8:7], lb_mid[col], w[5:4], lb_top[col], w[2:1]};
      vld <= (row >= ROW_TWO) && (col >= COL_TWO);
    end else begin
      vld <= vld && !win.out_ready;
    end
  end

  assign win.valid_out_buf = vld;
  assign win.pixel_0 = w[0];
  assign win.pixel_1 = w[1];
  assign win.pixel_2 = w[2];
  assign win.pixel_3 = w[3];
  assign win.pixel_4 = w[4];
  assign win.pixel_5 = w[5];
  assign win.pixel_6 = w[6];
  assign win.pixel_7 = w[7];
  assign win.pixel_8 = w[8];

`ifdef CONV1_WIN_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                     win_count <= '0;
    else if (start_ok)                              win_count <= '0;
    else if (vld && win.out_ready && win_count != 10'h3FF) win_count <= win_count + 10'd1;
  end
`endif

endmodule
